spi_flash_fetch: RTL
====================

# spi_flash_fetch

Fetch engine between the CPU core and an external SPI NOR flash holding the program image. On a request it latches a 24-bit byte address, issues a standard READ (0x03) transaction in SPI mode 0 and shifts in four bytes. It returns them as one little-endian 32-bit word over a four-phase start/done handshake. The core drives the pins directly from this block: sclk, mosi and cs to the pads, miso from a dedicated input.

## Interface
- CLK_DIV, 1: clk cycles per sclk half-period; legal range ≥1, values of 0 are illegal.
- READ_CMD, 8'h03: command byte shifted out first.

Ports:
- clk  in  1  system clock; every flop is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start_fetch  in  1  request; held high by the core until fetch_done is seen, then dropped.
- target_address  in  24  byte address; sampled only on the cycle a request is accepted.
- fetched_data  out  32  result word; stable from fetch_done rise until the next completion.
- fetch_done  out  1  completion flag.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data to flash.
- cs  out  1  flash chip select, active low.
- miso  in  1  SPI data from flash.

## Operation
- Reset values: cs=1, sclk=0, mosi=0, fetch_done=0, fetched_data=0, state IDLE, counters 0.
- States and transitions:
  - IDLE → SHIFT when start_fetch=1. In that cycle, latch {READ_CMD, target_address} into a 32-bit TX shift register and clear the RX shift register and bit counter.
  - SHIFT → DONE after 64 bits: 8 command, 24 address (MSB first), 32 data.
  - DONE → IDLE when start_fetch=0.
- SHIFT, per bit:
  - mosi presents TX MSB for the whole bit.
  - sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At the clk edge ending the high phase, miso is sampled into RX (bits 32..63 only) and TX shifts left with 0 fill.
  - mosi=0 during data bits.
- Byte order: the flash byte at address A arrives first, MSB-first. fetched_data = {byte A+3, byte A+2, byte A+1, byte A}.
- On leaving SHIFT, the same edge does all of: fetched_data←assembled word, fetch_done←1, cs←1, sclk←0.
- DONE holds fetch_done=1 while start_fetch=1. The first cycle start_fetch samples 0 clears fetch_done on that edge and returns to IDLE.
- Boundary cases:
  - start_fetch dropped mid-transfer: ignored. The transfer completes and fetch_done is high for exactly one cycle.
  - target_address changes mid-transfer: ignored; the latched value is used.
  - A new request is accepted only from IDLE. After DONE, at least one IDLE cycle precedes the next cs fall.
  - Address 24'hFFFFFC–FFFFFF: sent as-is. The wrap of bytes past FFFFFF is the flash's behaviour, not handled here.
  - rst_n low in any state, mid-bit included, forces reset values on the next edge. The flash sees cs rise and aborts.

## Timing
- E0 = edge at which IDLE samples start_fetch=1.
- From E0: cs=0, sclk=0, mosi=READ_CMD[7].
- For bit i (0..63):
  - sclk rises at E0+(2i+1)·CLK_DIV.
  - miso is sampled and sclk falls at E0+(2i+2)·CLK_DIV.
- fetch_done=1 and cs=1 after edge E0+128·CLK_DIV. With CLK_DIV=1 that is 128 cycles.
- fetch_done falls one edge after start_fetch is sampled low. The earliest next E0 is the edge after that.
- No combinational paths from inputs to outputs; all outputs are registered.

## Structure
- Shared package spi_fetch_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - SPI_READ_CMD = 8'h03;
  - FETCH_BITS = 64;
  - FETCH_DATA_BITS = 32.
- One sub-module, spi_sclk_div: a counter of width clog2(CLK_DIV)+1. It is enabled in SHIFT and emits rise/fall strobes every CLK_DIV cycles. The FSM and shift registers stay in spi_flash_fetch.

## Test plan
- CLK_DIV=1, address 24'h000000, flash model returns 13 05 10 00 → mosi shows 0x03,0x00,0x00,0x00. fetched_data=32'h00100513 and fetch_done rises 128 cycles after E0.
- CLK_DIV=3, address 24'h123456 → every sclk high and low phase is exactly 3 cycles. The 24 address bits match 0x123456 MSB-first and fetch_done is at E0+384.
- Hold start_fetch high 10 cycles past done, then drop → fetch_done stays high 10 cycles and falls 1 edge after the drop. The next request's cs fall follows one or more IDLE cycles later.
- Drop start_fetch at bit 20, toggle target_address mid-transfer → transaction uses the original address. fetch_done pulses for exactly one cycle.
- Assert rst_n=0 at bit 40 → the next edge gives cs=1, sclk=0, fetch_done=0, fetched_data=0. A new request after reset reads correctly.
- Address 24'hFFFFFC with model bytes DE AD BE EF → fetched_data=32'hEFBEADDE.

Source files
------------

// File: rtl/spi_fetch_pkg.sv
// Shared types and constants for the SPI NOR flash instruction fetch engine.
package spi_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  localparam logic [7:0] SPI_READ_CMD    = 8'h03;
  localparam int         FETCH_BITS      = 64;
  localparam int         FETCH_DATA_BITS = 32;

  // Flash delivers the lowest-addressed byte first; the core wants it in bits [7:0].
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_sclk_div.sv
// SCLK phase timer: strobes the end of each low and high half-period while enabled.
module spi_sclk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);
  localparam int              CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_high;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == LAST);
  assign o_rise = w_tick && !r_high;
  assign o_fall = w_tick && r_high;

  // Held cleared while disabled so every transfer starts with a full low phase.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_cnt  <= '0;
      r_high <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_high <= ~r_high;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_flash_fetch.sv
// Fetches one little-endian 32-bit word from SPI NOR flash with a mode-0 READ command.
module spi_flash_fetch
  import spi_fetch_pkg::*;
#(
  parameter int         CLK_DIV  = 1,
  parameter logic [7:0] READ_CMD = SPI_READ_CMD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_fetch,
  input  logic [23:0] target_address,
  output logic [31:0] fetched_data,
  output logic        fetch_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs,
  input  logic        miso
);
  fetch_state_t r_state;
  logic [31:0]  r_tx;
  logic [31:0]  r_rx;
  logic [5:0]   r_bit;
  logic         r_sclk;
  logic         r_cs;
  logic         r_done;
  logic [31:0]  r_data;

  logic         w_div_en;
  logic         w_rise;
  logic         w_fall;
  logic         w_last;
  logic         w_data_bit;
  logic [31:0]  w_rx_next;

  assign w_div_en   = (r_state == SHIFT);
  assign w_last     = (r_bit == 6'(FETCH_BITS - 1));
  assign w_data_bit = (r_bit >= 6'(FETCH_BITS - FETCH_DATA_BITS));
  assign w_rx_next  = {r_rx[30:0], miso};

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_div_en),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_rx    <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_fetch) begin
          r_state <= SHIFT;
          r_tx    <= {READ_CMD, target_address};
          r_rx    <= '0;
          r_bit   <= '0;
          r_cs    <= 1'b0;
          r_sclk  <= 1'b0;
        end
        SHIFT: begin
          if (w_rise) r_sclk <= 1'b1;
          // Zero fill means mosi naturally idles low once cmd+addr are out.
          if (w_fall) begin
            r_sclk <= 1'b0;
            r_tx   <= {r_tx[30:0], 1'b0};
            r_bit  <= r_bit + 1'b1;
            if (w_data_bit) r_rx <= w_rx_next;
            if (w_last) begin
              r_state <= DONE;
              r_data  <= bswap32(w_rx_next);
              r_done  <= 1'b1;
              r_cs    <= 1'b1;
            end
          end
        end
        DONE: if (!start_fetch) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetched_data = r_data;
  assign fetch_done   = r_done;
  assign sclk         = r_sclk;
  assign mosi         = r_tx[31];
  assign cs           = r_cs;
endmodule
